// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one fixed-latency word memory between the
// instruction-fetch port (I) and the load/store port (D), with byte loads and read-modify-write byte stores.
module mem_port_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR,
    RMW_WAIT,
    RMW_WR,
    ERR_ACK
  } state_t;

  localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant_d;
  logic              cur_d;
  logic              cur_byte;
  logic [1:0]        cur_lane;
  logic [7:0]        cur_wbyte;

  logic              i_pend;
  logic              d_pend;
  logic              any_pend;
  logic              tie;
  logic              grant_d;
  logic [ADDR_W-1:0] g_addr;
  logic              g_store;
  logic              g_byte;
  logic              misaligned;
  logic              data_valid;

  logic [4:0]        shamt;
  logic [31:0]       lane_shifted;
  logic [31:0]       merged;

  logic              i_ack_n;
  logic [31:0]       i_rdata_n;
  logic              i_err_n;
  logic              d_ack_n;
  logic [31:0]       d_rdata_n;
  logic              d_err_n;
  logic              mem_en_n;
  logic              mem_we_n;
  logic [ADDR_W-3:0] mem_addr_n;
  logic [31:0]       mem_wdata_n;

  // A port whose ack is high this cycle is still holding its old request, so it is masked.
  always_comb begin
    i_pend     = i_req & ~i_ack;
    d_pend     = d_req & ~d_ack;
    any_pend   = i_pend | d_pend;
    tie        = i_pend & d_pend;
    grant_d    = d_pend & (~i_pend | ~last_grant_d);
    g_addr     = grant_d ? d_addr : i_addr;
    g_store    = grant_d & d_we;
    g_byte     = grant_d & d_size;
    misaligned = (g_addr[1:0] != 2'b00) & ~g_byte;
  end

  assign data_valid = (cnt == LAT);

  // Big-endian lanes: lane 0 lives in bits 31:24, lane 3 in bits 7:0.
  assign shamt        = {2'd3 - cur_lane, 3'b000};
  assign lane_shifted = mem_rdata >> shamt;
  assign merged       = (mem_rdata & ~(32'h0000_00FF << shamt)) |
                        ({24'd0, cur_wbyte} << shamt);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant_d <= 1'b1;
      cur_d        <= 1'b0;
      cur_byte     <= 1'b0;
      cur_lane     <= 2'b00;
      cur_wbyte    <= 8'h00;
      i_ack        <= 1'b0;
      i_rdata      <= 32'h0;
      i_err        <= 1'b0;
      d_ack        <= 1'b0;
      d_rdata      <= 32'h0;
      d_err        <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'h0;
    end else begin
      state     <= state_nxt;
      cnt       <= (state == IDLE) ? '0 : cnt + 1'b1;
      i_ack     <= i_ack_n;
      i_rdata   <= i_rdata_n;
      i_err     <= i_err_n;
      d_ack     <= d_ack_n;
      d_rdata   <= d_rdata_n;
      d_err     <= d_err_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if (state == IDLE && any_pend) begin
        cur_d     <= grant_d;
        cur_byte  <= g_byte;
        cur_lane  <= g_addr[1:0];
        cur_wbyte <= d_wdata[7:0];
        if (tie) begin
          last_grant_d <= grant_d;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_pend) begin
          if (misaligned) begin
            state_nxt = ERR_ACK;
          end else if (!g_store) begin
            state_nxt = RD_WAIT;
          end else if (g_byte) begin
            state_nxt = RMW_WAIT;
          end else begin
            state_nxt = WR;
          end
        end
      end
      RD_WAIT: begin
        if (data_valid) begin
          state_nxt = IDLE;
        end
      end
      RMW_WAIT: begin
        if (data_valid) begin
          state_nxt = RMW_WR;
        end
      end
      WR, RMW_WR, ERR_ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; rdata, address and write data hold unless updated.
  always_comb begin
    i_ack_n     = 1'b0;
    i_rdata_n   = i_rdata;
    i_err_n     = 1'b0;
    d_ack_n     = 1'b0;
    d_rdata_n   = d_rdata;
    d_err_n     = 1'b0;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    case (state)
      IDLE: begin
        if (any_pend) begin
          if (misaligned) begin
            if (grant_d) begin
              d_ack_n   = 1'b1;
              d_err_n   = 1'b1;
              d_rdata_n = 32'h0;
            end else begin
              i_ack_n   = 1'b1;
              i_err_n   = 1'b1;
              i_rdata_n = 32'h0;
            end
          end else begin
            mem_en_n   = 1'b1;
            mem_addr_n = g_addr[ADDR_W-1:2];
            if (g_store && !g_byte) begin
              mem_we_n    = 1'b1;
              mem_wdata_n = d_wdata;
            end
          end
        end
      end
      RD_WAIT: begin
        if (data_valid) begin
          if (cur_d) begin
            d_ack_n   = 1'b1;
            d_rdata_n = cur_byte ? {24'd0, lane_shifted[7:0]} : mem_rdata;
          end else begin
            i_ack_n   = 1'b1;
            i_rdata_n = mem_rdata;
          end
        end
      end
      RMW_WAIT: begin
        if (data_valid) begin
          mem_en_n    = 1'b1;
          mem_we_n    = 1'b1;
          mem_wdata_n = merged;
        end
      end
      WR, RMW_WR: d_ack_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: word memory models at latency 1 and 3, a per-port
// scoreboard of expected acks, a vector table, and tie/latency/reset sequences.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req;
  logic [11:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic        d_size;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        l3_i_req;
  logic [11:0] l3_i_addr;
  logic        l3_i_ack;
  logic [31:0] l3_i_rdata;
  logic        l3_i_err;
  logic        l3_d_req;
  logic        l3_d_we;
  logic        l3_d_size;
  logic [11:0] l3_d_addr;
  logic [31:0] l3_d_wdata;
  logic        l3_d_ack;
  logic [31:0] l3_d_rdata;
  logic        l3_d_err;
  logic        l3_mem_en;
  logic        l3_mem_we;
  logic [9:0]  l3_mem_addr;
  logic [31:0] l3_mem_wdata;
  logic [31:0] l3_mem_rdata;

  int checks;
  int failures;
  int cyc;
  int en_cnt;
  int we_cnt;
  bit mon_on;

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
    bit          err;
    int          due;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];

  typedef struct {
    bit          is_d;
    bit          we;
    bit          sz;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          idx;
    logic [31:0] preload;
    logic [31:0] exp_rdata;
    bit          chk;
    bit          exp_err;
    int          lat;
    int          exp_en;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[12];

  mem_port_arbiter #(.ADDR_W(12), .MEM_LATENCY(1)) u_dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(12), .MEM_LATENCY(3)) u_dut_l3 (
    .clock(clock), .reset(reset),
    .i_req(l3_i_req), .i_addr(l3_i_addr), .i_ack(l3_i_ack), .i_rdata(l3_i_rdata),
    .i_err(l3_i_err),
    .d_req(l3_d_req), .d_we(l3_d_we), .d_size(l3_d_size), .d_addr(l3_d_addr),
    .d_wdata(l3_d_wdata), .d_ack(l3_d_ack), .d_rdata(l3_d_rdata), .d_err(l3_d_err),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
    .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory models: read data is valid exactly MEM_LATENCY cycles after mem_en, garbage otherwise.
  logic [31:0] mem1 [0:1023];
  logic [31:0] p1;
  logic        v1;
  always @(posedge clock) begin
    if (mem_en && mem_we) mem1[mem_addr] = mem_wdata;
    p1 <= mem1[mem_addr];
    v1 <= mem_en & ~mem_we;
  end
  assign mem_rdata = v1 ? p1 : 32'hDEAD_BEEF;

  logic [31:0] mem3 [0:1023];
  logic [31:0] p3 [0:2];
  logic [2:0]  v3;
  always @(posedge clock) begin
    if (l3_mem_en && l3_mem_we) mem3[l3_mem_addr] = l3_mem_wdata;
    p3[0] <= mem3[l3_mem_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    v3    <= {v3[1:0], l3_mem_en & ~l3_mem_we};
  end
  assign l3_mem_rdata = v3[2] ? p3[2] : 32'hDEAD_BEEF;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_i_ack"}, {31'd0, i_ack}, 32'd0);
    check_output({tag, "_i_rdata"}, i_rdata, 32'd0);
    check_output({tag, "_i_err"}, {31'd0, i_err}, 32'd0);
    check_output({tag, "_d_ack"}, {31'd0, d_ack}, 32'd0);
    check_output({tag, "_d_rdata"}, d_rdata, 32'd0);
    check_output({tag, "_d_err"}, {31'd0, d_err}, 32'd0);
    check_output({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    check_output({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check_output({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
    check_output({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // Raise one request, push its expected completion, wait (bounded) for the ack, then drop it.
  task automatic apply_stimulus(input bit is_d, input bit we, input bit sz,
                                input logic [11:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input bit chk,
                                input bit exp_err, input int lat);
    exp_t e;
    bit   got;
    @(posedge clock);
    #1;
    e.rdata = exp_rdata;
    e.chk   = chk;
    e.err   = exp_err;
    e.due   = cyc + lat;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_size = sz; d_addr = addr; d_wdata = wdata;
      dq.push_back(e);
    end else begin
      i_req = 1'b1; i_addr = addr;
      iq.push_back(e);
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      if (is_d ? d_ack : i_ack) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("[TB] FAIL ack_timeout: got no ack, expected one within 40 cycles (addr 0x%03h)", addr);
    end
    @(posedge clock);
    #1;
    if (is_d) d_req = 1'b0;
    else      i_req = 1'b0;
  endtask

  // Scoreboard and per-cycle invariants, sampled on the falling edge.
  always @(negedge clock) begin
    if (mon_on) begin
      exp_t e;
      check_output("one_ack_per_cycle", {31'd0, i_ack & d_ack}, 32'd0);
      check_output("we_without_en", {31'd0, mem_we & ~mem_en}, 32'd0);
      check_output("err_outside_ack", {31'd0, (i_err & ~i_ack) | (d_err & ~d_ack)}, 32'd0);
      if (mem_en) en_cnt++;
      if (mem_we) we_cnt++;
      if (i_ack) begin
        checks++;
        if (iq.size() == 0) begin
          failures++;
          $display("[TB] FAIL i_unexpected_ack: got ack at cycle %0d, expected none", cyc);
        end else begin
          e = iq.pop_front();
          if (e.chk) check_output("i_rdata", i_rdata, e.rdata);
          check_output("i_err", {31'd0, i_err}, {31'd0, e.err});
          check_output("i_ack_cycle", cyc, e.due);
        end
      end
      if (d_ack) begin
        checks++;
        if (dq.size() == 0) begin
          failures++;
          $display("[TB] FAIL d_unexpected_ack: got ack at cycle %0d, expected none", cyc);
        end else begin
          e = dq.pop_front();
          if (e.chk) check_output("d_rdata", d_rdata, e.rdata);
          check_output("d_err", {31'd0, d_err}, {31'd0, e.err});
          check_output("d_ack_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int en0;
    int we0;
    int start;
    int ack_cyc;
    bit got;

    checks = 0; failures = 0; cyc = 0; en_cnt = 0; we_cnt = 0; mon_on = 1'b0;
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 1'b0; d_addr = '0; d_wdata = '0;
    l3_i_req = 1'b0; l3_i_addr = '0;
    l3_d_req = 1'b0; l3_d_we = 1'b0; l3_d_size = 1'b0; l3_d_addr = '0; l3_d_wdata = '0;
    for (int k = 0; k < 1024; k++) begin
      mem1[k] = 32'h0;
      mem3[k] = 32'h0;
    end

    //                is_d we sz addr    wdata         idx preload       exp_rdata     chk err lat en exp_mem
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 12'h008, 32'h0,        2,  32'h20080007, 32'h20080007, 1'b1, 1'b0, 3, 1, 32'h20080007};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 12'h078, 32'h0,        30, 32'h11223344, 32'h11223344, 1'b1, 1'b0, 3, 1, 32'h11223344};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 12'h079, 32'h000000AB, 30, 32'h11223344, 32'h0,        1'b0, 1'b0, 4, 2, 32'h11AB3344};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 12'h07A, 32'h0,        30, 32'h11223344, 32'h0,        1'b1, 1'b1, 1, 0, 32'h11223344};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 12'h07B, 32'h0,        30, 32'h11223344, 32'h00000044, 1'b1, 1'b0, 3, 1, 32'h11223344};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 12'h078, 32'h0,        30, 32'h11223344, 32'h00000011, 1'b1, 1'b0, 3, 1, 32'h11223344};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 12'h100, 32'hCAFEF00D, 64, 32'h12345678, 32'h0,        1'b0, 1'b0, 2, 1, 32'hCAFEF00D};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 12'h101, 32'h0,        64, 32'h12345678, 32'h0,        1'b1, 1'b1, 1, 0, 32'h12345678};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 12'h07C, 32'h0000005A, 31, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 4, 2, 32'h5AFFFFFF};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 12'h102, 32'hCAFEF00D, 64, 32'h12345678, 32'h0,        1'b1, 1'b1, 1, 0, 32'h12345678};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 12'h07E, 32'h0,        31, 32'hA1B2C3D4, 32'h000000C3, 1'b1, 1'b0, 3, 1, 32'hA1B2C3D4};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 12'h07F, 32'hFFFFFF77, 31, 32'h00000000, 32'h0,        1'b0, 1'b0, 4, 2, 32'h00000077};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset");
    mon_on = 1'b1;

    // Fetch timing: mem_en only in cycle 1 with word index 2, ack in cycle 3.
    mem1[2] = 32'h20080007;
    fork
      apply_stimulus(1'b0, 1'b0, 1'b0, 12'h008, 32'h0, 32'h20080007, 1'b1, 1'b0, 3);
      begin
        @(posedge clock);
        #1;
        @(negedge clock);
        check_output("fetch_mem_en_c0", {31'd0, mem_en}, 32'd0);
        @(negedge clock);
        check_output("fetch_mem_en_c1", {31'd0, mem_en}, 32'd1);
        check_output("fetch_mem_we_c1", {31'd0, mem_we}, 32'd0);
        check_output("fetch_mem_addr_c1", {22'd0, mem_addr}, 32'd2);
        @(negedge clock);
        check_output("fetch_mem_en_c2", {31'd0, mem_en}, 32'd0);
      end
    join

    for (int v = 0; v < 12; v++) begin
      mem1[vecs[v].idx] = vecs[v].preload;
      en0 = en_cnt;
      apply_stimulus(vecs[v].is_d, vecs[v].we, vecs[v].sz, vecs[v].addr, vecs[v].wdata,
                     vecs[v].exp_rdata, vecs[v].chk, vecs[v].exp_err, vecs[v].lat);
      check_output($sformatf("v%0d_mem_en_count", v), en_cnt - en0, vecs[v].exp_en);
      check_output($sformatf("v%0d_mem_word", v), mem1[vecs[v].idx], vecs[v].exp_mem);
    end

    // Two simultaneous requests twice: I wins the first tie, D the second.
    mem1[2]  = 32'h20080007;
    mem1[30] = 32'h11223344;
    en0 = en_cnt;
    fork
      apply_stimulus(1'b0, 1'b0, 1'b0, 12'h008, 32'h0, 32'h20080007, 1'b1, 1'b0, 3);
      apply_stimulus(1'b1, 1'b0, 1'b0, 12'h078, 32'h0, 32'h11223344, 1'b1, 1'b0, 6);
    join
    check_output("tie1_mem_en_count", en_cnt - en0, 32'd2);
    en0 = en_cnt;
    fork
      apply_stimulus(1'b0, 1'b0, 1'b0, 12'h008, 32'h0, 32'h20080007, 1'b1, 1'b0, 6);
      apply_stimulus(1'b1, 1'b0, 1'b0, 12'h078, 32'h0, 32'h11223344, 1'b1, 1'b0, 3);
    join
    check_output("tie2_mem_en_count", en_cnt - en0, 32'd2);

    // Byte load through the latency-3 instance: ack in cycle 5.
    mem3[30] = 32'h11223344;
    @(posedge clock);
    #1;
    l3_d_req = 1'b1; l3_d_we = 1'b0; l3_d_size = 1'b1; l3_d_addr = 12'h07B;
    start = cyc;
    got = 1'b0;
    ack_cyc = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clock);
      if (l3_d_ack) begin
        got = 1'b1;
        ack_cyc = cyc;
      end
    end
    check_output("l3_ack_seen", {31'd0, got}, 32'd1);
    check_output("l3_ack_cycle", ack_cyc - start, 32'd5);
    check_output("l3_d_rdata", l3_d_rdata, 32'h00000044);
    check_output("l3_d_err", {31'd0, l3_d_err}, 32'd0);
    @(posedge clock);
    #1 l3_d_req = 1'b0;

    // Reset while the byte store waits for its read data: nothing is written or acked.
    mem1[30] = 32'h11223344;
    we0 = we_cnt;
    @(posedge clock);
    #1;
    d_req = 1'b1; d_we = 1'b1; d_size = 1'b1; d_addr = 12'h079; d_wdata = 32'h000000AB;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_output("rst_read_issued", {31'd0, mem_en}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    d_req = 1'b0;
    @(negedge clock);
    check_all_zero("post_reset");
    repeat (5) @(negedge clock);
    check_output("rst_no_write", we_cnt - we0, 32'd0);
    check_output("rst_mem_unchanged", mem1[30], 32'h11223344);

    check_output("i_queue_drained", iq.size(), 32'd0);
    check_output("d_queue_drained", dq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
